// File: rtl/dmem_mmio.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO page (LED, timer, status).
// The debug byte FIFO at 0x8000_0010 is built only when DBG_FIFO_EN is defined.
module dmem_mmio #(
  parameter int RAM_WORDS = 64,
  parameter int DBG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic        irq,
  output logic        dbg_valid,
  output logic [7:0]  dbg_data,
  input  logic        dbg_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [29:0] PAGE = 30'h2000_0000;

  logic [29:0] wadr;
  logic        ram_sel, sel_led, sel_time, sel_cmp, sel_stat, sel_dbg;
  logic [1:0]  unused_lsb;

  assign wadr       = DataAdr[31:2];
  assign unused_lsb = DataAdr[1:0];
  assign ram_sel    = (DataAdr[31:AW+2] == '0);
  assign sel_led    = (wadr == PAGE);
  assign sel_time   = (wadr == PAGE + 30'd1);
  assign sel_cmp    = (wadr == PAGE + 30'd2);
  assign sel_stat   = (wadr == PAGE + 30'd3);
  assign sel_dbg    = (wadr == PAGE + 30'd4);

  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel) mem_q[DataAdr[AW+1:2]] <= WriteData;
  end

  logic [7:0]  led_q, led_d;
  logic [31:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic        match_q, match_d, ie_q, ie_d, ovf_q, ovf_d;
  logic        st_wr, ovf_set;
  logic [31:0] dbg_rdata;

`ifdef DBG_FIFO_EN
  localparam int PW = $clog2(DBG_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    fifo_q [DBG_DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          full, empty, push, pop, push_ok;

  assign full    = (cnt_q == CW'(DBG_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push    = MemWrite & sel_dbg;
  assign pop     = ~empty & dbg_ready;
  // A pop in the same cycle frees the slot the full-FIFO push needs.
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_q + PW'(pop);
      wr_q  <= wr_q + PW'(push_ok);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_q] <= WriteData[7:0];
  end

  assign dbg_valid = ~empty;
  assign dbg_data  = fifo_q[rd_q];
  assign dbg_rdata = {16'b0, 8'(cnt_q), 6'b0, full, empty};
`else
  logic unused_dbg;
  assign unused_dbg = dbg_ready ^ sel_dbg;
  assign ovf_set    = 1'b0;
  assign dbg_valid  = 1'b0;
  assign dbg_data   = 8'h00;
  assign dbg_rdata  = 32'h0;
`endif

  always_comb begin
    st_wr   = MemWrite & sel_stat;
    led_d   = (MemWrite && sel_led) ? WriteData[7:0] : led_q;
    mtime_d = (MemWrite && sel_time) ? WriteData : mtime_q + 32'd1;
    cmp_d   = (MemWrite && sel_cmp) ? WriteData : cmp_q;
    // Sticky flags: set terms are ORed after the clear so set wins.
    match_d = (mtime_q == cmp_q) | (match_q & ~(st_wr & WriteData[0]));
    ie_d    = st_wr ? WriteData[1] : ie_q;
    ovf_d   = ovf_set | (ovf_q & ~(st_wr & WriteData[2]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= 8'h00;
      mtime_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      led_q   <= led_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
    end
  end

  assign leds = led_q;
  assign irq  = match_q & ie_q;

  always_comb begin
    ReadData = 32'h0;
    if (ram_sel)       ReadData = mem_q[DataAdr[AW+1:2]];
    else if (sel_led)  ReadData = {24'b0, led_q};
    else if (sel_time) ReadData = mtime_q;
    else if (sel_cmp)  ReadData = cmp_q;
    else if (sel_stat) ReadData = {29'b0, ovf_q, ie_q, match_q};
    else if (sel_dbg)  ReadData = dbg_rdata;
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized bench for dmem_mmio against a transaction-level reference model, plus directed scenarios.
module tb_dmem_mmio;
  localparam int RW = 64;
  localparam int DD = 4;
`ifdef DBG_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam logic [31:0] A_LED  = 32'h8000_0000;
  localparam logic [31:0] A_TIME = 32'h8000_0004;
  localparam logic [31:0] A_CMP  = 32'h8000_0008;
  localparam logic [31:0] A_STAT = 32'h8000_000C;
  localparam logic [31:0] A_DBG  = 32'h8000_0010;

  logic        clk = 1'b0, reset, MemWrite, dbg_ready;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic [7:0]  leds, dbg_data;
  logic        irq, dbg_valid;

  always #5 clk = ~clk;

  dmem_mmio #(.RAM_WORDS(RW), .DBG_DEPTH(DD)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .leds(leds), .irq(irq),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_ram [RW];
  bit          m_known [RW];
  logic [7:0]  m_led;
  logic [31:0] m_time, m_cmp;
  bit          m_match, m_ie, m_ovf;
  logic [7:0]  m_q [$];
  logic [31:0] rd_obs;

  task automatic m_reset();
    m_led = 8'h00; m_time = 32'h0; m_cmp = 32'hFFFF_FFFF;
    m_match = 0; m_ie = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    logic [31:0] aw;
    aw = a & ~32'h3;
    known = 1;
    v = 32'h0;
    if (a < 32'(4 * RW)) begin
      known = m_known[a / 4];
      v = m_ram[a / 4];
    end else if (aw == A_LED)  v = {24'b0, m_led};
    else if (aw == A_TIME) v = m_time;
    else if (aw == A_CMP)  v = m_cmp;
    else if (aw == A_STAT) v = {29'b0, m_ovf, m_ie, m_match};
    else if (aw == A_DBG && FIFO_EN)
      v = {16'b0, 8'(m_q.size()), 6'b0, m_q.size() == DD, m_q.size() == 0};
  endtask

  task automatic m_step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    bit hit, pop, push, ovf_hit;
    logic [31:0] aw;
    aw = a & ~32'h3;
    hit = (m_time == m_cmp);
    pop = FIFO_EN && m_q.size() > 0 && rdy;
    push = 0; ovf_hit = 0;
    m_time = m_time + 32'd1;
    if (we) begin
      if (a < 32'(4 * RW)) begin
        m_ram[a / 4] = wd; m_known[a / 4] = 1;
      end else if (aw == A_LED)  m_led = wd[7:0];
      else if (aw == A_TIME) m_time = wd;
      else if (aw == A_CMP)  m_cmp = wd;
      else if (aw == A_STAT) begin
        if (wd[0]) m_match = 0;
        if (wd[2]) m_ovf = 0;
        m_ie = wd[1];
      end else if (aw == A_DBG && FIFO_EN) begin
        if (m_q.size() == DD && !pop) ovf_hit = 1;
        else push = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(wd[7:0]);
    if (hit) m_match = 1;
    if (ovf_hit) m_ovf = 1;
  endtask

  // One bus cycle: drive, check outputs before the edge, clock, advance the model.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    logic [31:0] exp;
    bit known;
    MemWrite = we; DataAdr = a; WriteData = wd; dbg_ready = rdy;
    #2;
    m_read(a, exp, known);
    if (known) chk("rdata", ReadData, exp);
    rd_obs = ReadData;
    chk("leds", {24'b0, leds}, {24'b0, m_led});
    chk("irq", {31'b0, irq}, {31'b0, m_match & m_ie});
    chk("dbg_valid", {31'b0, dbg_valid}, {31'b0, m_q.size() > 0});
`ifdef DBG_FIFO_EN
    if (m_q.size() > 0) chk("dbg_data", {24'b0, dbg_data}, {24'b0, m_q[0]});
`else
    chk("dbg_data", {24'b0, dbg_data}, 32'h0);
`endif
    @(posedge clk);
    #1;
    m_step(we, a, wd, rdy);
  endtask

  function automatic logic [31:0] rand_adr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: rand_adr = 32'($urandom_range(0, RW - 1) * 4 + $urandom_range(0, 3));
      4: rand_adr = A_LED  | 32'($urandom_range(0, 3));
      5: rand_adr = A_TIME;
      6: rand_adr = A_CMP;
      7: rand_adr = A_STAT;
      8: rand_adr = A_DBG;
      default: rand_adr = {2'b01, 30'($urandom)};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, wd;
    for (int i = 0; i < RW; i++) m_known[i] = 0;
    reset = 1; MemWrite = 0; DataAdr = 0; WriteData = 0; dbg_ready = 0;
    m_reset();
    #3;
    chk("rst_leds", {24'b0, leds}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_dbg_valid", {31'b0, dbg_valid}, 32'h0);
    @(negedge clk);
    reset = 0;
    #1;
    cyc(0, A_CMP, 0, 0);
    chk("rst_cmp", rd_obs, 32'hFFFF_FFFF);

    for (int n = 0; n < 400; n++) begin
      a = rand_adr();
      wd = $urandom;
      if ((a & ~32'h3) == A_CMP || (a & ~32'h3) == A_TIME)
        wd = m_time + 32'($urandom_range(0, 8));
      cyc(1'($urandom_range(0, 1)), a, wd, 1'($urandom_range(0, 1)));
    end

    cyc(1, 32'h10, 32'hDEAD_BEEF, 0);
    cyc(0, 32'h10, 0, 0);
    chk("ram_rd", rd_obs, 32'hDEAD_BEEF);
    cyc(0, 32'h13, 0, 0);
    chk("ram_rd_lsb", rd_obs, 32'hDEAD_BEEF);
    cyc(0, 32'h4000_0000, 0, 0);
    chk("unmapped_rd", rd_obs, 32'h0);

    cyc(1, A_TIME, 1000, 0);
    cyc(1, A_CMP, 15, 0);
    cyc(1, A_STAT, 32'h7, 0);
    cyc(1, A_TIME, 10, 0);
    for (int k = 0; k < 5; k++) cyc(0, A_LED, 0, 0);
    chk("irq_before_match", {31'b0, irq}, 32'h0);
    cyc(0, A_LED, 0, 0);
    chk("irq_at_match", {31'b0, irq}, 32'h1);
    cyc(1, A_STAT, 32'h3, 0);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    cyc(0, A_STAT, 0, 0);
    chk("ie_kept", rd_obs, 32'h2);

    cyc(1, A_TIME, 13, 0);
    cyc(0, A_LED, 0, 0);
    cyc(0, A_LED, 0, 0);
    cyc(1, A_STAT, 32'h3, 0);
    chk("set_wins_irq", {31'b0, irq}, 32'h1);
    cyc(0, A_STAT, 0, 0);
    chk("set_wins_stat", rd_obs, 32'h3);

    cyc(1, A_TIME, 32'hFFFF_FFFE, 0);
    cyc(0, A_LED, 0, 0);
    cyc(0, A_LED, 0, 0);
    cyc(0, A_TIME, 0, 0);
    chk("mtime_wrap", rd_obs, 32'h0);

    cyc(1, A_LED, 32'hA5, 0);
    cyc(0, A_TIME, 0, 0);
    chk("led_a5", {24'b0, leds}, 32'hA5);
    #2;
    reset = 1;
    #1;
    chk("async_rst_leds", {24'b0, leds}, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    chk("async_rst_dbg_valid", {31'b0, dbg_valid}, 32'h0);
    m_reset();
    @(negedge clk);
    reset = 0;
    #1;
    chk("mtime_after_rst", ReadData, 32'h0);
    cyc(0, A_CMP, 0, 0);
    chk("cmp_after_rst", rd_obs, 32'hFFFF_FFFF);
    cyc(0, 32'h10, 0, 0);
    chk("ram_survives_rst", rd_obs, 32'hDEAD_BEEF);

`ifdef DBG_FIFO_EN
    for (int i = 0; i < 5; i++) cyc(1, A_DBG, 32'h41 + 32'(i), 0);
    cyc(0, A_STAT, 0, 0);
    chk("ovf_set", rd_obs & 32'h4, 32'h4);
    cyc(0, A_DBG, 0, 0);
    chk("dbg_full", rd_obs, 32'h0000_0402);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'b0, dbg_valid}, 32'h1);
      chk("drain_byte", {24'b0, dbg_data}, 32'h41 + 32'(i));
      cyc(0, A_LED, 0, 1);
    end
    chk("drained_valid", {31'b0, dbg_valid}, 32'h0);
    cyc(0, A_DBG, 0, 1);
    chk("dbg_empty", rd_obs, 32'h1);
`else
    cyc(1, A_DBG, 32'h55, 1);
    cyc(0, A_DBG, 0, 1);
    chk("dbg_absent_rd", rd_obs, 32'h0);
    chk("dbg_absent_valid", {31'b0, dbg_valid}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
